// File: rtl/cdc_hs_pkg.sv
// Shared definitions for the four-phase req/ack source-side handshake controller.
package cdc_hs_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] REQ   = 2'd2;
  localparam logic [1:0] REL   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_SETUP = SETUP,
    ST_REQ   = REQ,
    ST_REL   = REL
  } hs_state_t;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/cdc_hs_timeout.sv
// Saturating phase counter; expired is high while the count sits on the last allowed cycle.
module cdc_hs_timeout
  import cdc_hs_pkg::*;
#(
  parameter int unsigned CNT_WIDTH      = 16,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned            LIMIT_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CNT_WIDTH-1:0]   LIMIT   = CNT_WIDTH'(LIMIT_I);

  logic [CNT_WIDTH-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // A zero TIMEOUT_CYCLES disables detection entirely.
  assign expired = (TIMEOUT_CYCLES != 0) && (cnt == LIMIT);

endmodule

// File: rtl/cdc_hs_src_ctrl.sv
// Source-domain controller for a four-phase req/ack word transfer with a one-entry
// pending buffer, per-phase timeout and sticky protocol-error flags.
module cdc_hs_src_ctrl
  import cdc_hs_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0] data_s,
  output logic                  req_s,
  input  logic                  ack_sync,
  output logic                  busy,
  output logic                  done_pulse,
  output logic                  err_timeout,
  output logic                  err_proto,
  input  logic                  err_clr
);

  hs_state_t             state, state_n;
  logic [DATA_WIDTH-1:0] pend_data;
  logic                  pend_full;
  logic                  accept;
  logic                  rel_exit;
  logic                  load_from_in;
  logic                  load_from_pend;
  logic                  pend_load;
  logic                  phase_active;
  logic                  phase_expired;
  logic                  timeout_set;
  logic                  proto_set;

  // in_ready depends only on registered state, never on ack_sync.
  assign in_ready       = ~pend_full;
  assign accept         = in_valid & in_ready;
  assign busy           = (state != ST_IDLE) | pend_full;
  assign load_from_in   = accept & (state == ST_IDLE);
  assign pend_load      = accept & (state != ST_IDLE);
  assign load_from_pend = rel_exit & pend_full;
  assign phase_active   = (state == ST_REQ) | (state == ST_REL);

  always_comb begin
    state_n  = state;
    rel_exit = 1'b0;
    case (state)
      ST_IDLE:  if (accept) state_n = ST_SETUP;
      ST_SETUP: state_n = ST_REQ;
      ST_REQ:   if (ack_sync) state_n = ST_REL;
      ST_REL: begin
        if (!ack_sync) begin
          rel_exit = 1'b1;
          state_n  = pend_full ? ST_SETUP : ST_IDLE;
        end
      end
      default:  state_n = ST_IDLE;
    endcase
  end

  cdc_hs_timeout #(
    .CNT_WIDTH      (CNT_WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_n != state),
    .en      (phase_active),
    .expired (phase_expired)
  );

  // The phase is still outstanding when ack has not yet taken the level this state waits for.
  assign timeout_set = phase_expired &
                       (((state == ST_REQ) & ~ack_sync) | ((state == ST_REL) & ack_sync));
  assign proto_set   = ack_sync & ((state == ST_IDLE) | (state == ST_SETUP));

  // Handshake state and the cross-domain flops (req_s, data_s).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      req_s      <= 1'b0;
      data_s     <= '0;
      done_pulse <= 1'b0;
    end else begin
      state      <= state_n;
      req_s      <= (state_n == ST_REQ);
      done_pulse <= rel_exit;
      if (load_from_in) begin
        data_s <= in_data;
      end else if (load_from_pend) begin
        data_s <= pend_data;
      end
    end
  end

  // Pending buffer; an accept can only happen while it is empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_full <= 1'b0;
      pend_data <= '0;
    end else if (load_from_pend) begin
      pend_full <= 1'b0;
    end else if (pend_load) begin
      pend_full <= 1'b1;
      pend_data <= in_data;
    end
  end

  // Sticky error flags; a set in the same cycle overrides err_clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_timeout <= 1'b0;
      err_proto   <= 1'b0;
    end else begin
      if (timeout_set) begin
        err_timeout <= 1'b1;
      end else if (err_clr) begin
        err_timeout <= 1'b0;
      end
      if (proto_set) begin
        err_proto <= 1'b1;
      end else if (err_clr) begin
        err_proto <= 1'b0;
      end
    end
  end

endmodule
